// File: rtl/tw_core_if.sv
// Program-memory fetch channel for tw_core: the core presents pc with a request,
// memory answers with fetch_valid and the instruction word when it is ready.
interface tw_core_if #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4
);
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_valid;
   logic [DATA_W+3:0] fetch_data;

   modport master (
      output fetch_req,
      output fetch_addr,
      input  fetch_valid,
      input  fetch_data
   );

   modport slave (
      input  fetch_req,
      input  fetch_addr,
      output fetch_valid,
      output fetch_data
   );
endinterface

// File: rtl/tw_core.sv
// tw_core: parametrised two-register (A, B) accumulator core with a fetch/execute FSM,
// wait-state tolerant program fetch, synchronised input port, output strobe and halt detect.
module tw_core #(
   parameter int DATA_W      = 4,
   parameter int ADDR_W      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clock,
   input  logic              reset,
   tw_core_if.master         fetch,
   input  logic [DATA_W-1:0] in_port,
   output logic [DATA_W-1:0] out_port,
   output logic              out_strobe,
   output logic              carry,
   output logic              halted
);

   typedef enum logic {
      S_FETCH,
      S_EXEC
   } state_e;

   typedef enum logic [3:0] {
      OP_ADD_A  = 4'b0000,
      OP_MOV_AB = 4'b0001,
      OP_IN_A   = 4'b0010,
      OP_MOV_AI = 4'b0011,
      OP_MOV_BA = 4'b0100,
      OP_ADD_B  = 4'b0101,
      OP_IN_B   = 4'b0110,
      OP_MOV_BI = 4'b0111,
      OP_OUT_B  = 4'b1001,
      OP_OUT_I  = 4'b1011,
      OP_JMP    = 4'b1110,
      OP_JNC    = 4'b1111
   } opcode_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W+3:0] ir_q, ir_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic              carry_q, carry_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic              strobe_q, strobe_d;
   logic              halted_q, halted_d;

   logic [DATA_W-1:0] sync_q [SYNC_STAGES];
   logic [DATA_W-1:0] sync_in;

   logic [3:0]        opcode;
   logic [DATA_W-1:0] imm;
   logic [DATA_W-1:0] add_op;
   logic [DATA_W:0]   add_sum;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] jump_tgt;
   logic              jump_taken;

   // in_port is asynchronous to clock; only the last stage is ever consumed.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign sync_in  = sync_q[SYNC_STAGES-1];
   assign opcode   = ir_q[DATA_W+3:DATA_W];
   assign imm      = ir_q[DATA_W-1:0];
   // One adder serves both ADD A and ADD B; opcode bit 2 selects the operand.
   assign add_op   = opcode[2] ? b_q : a_q;
   assign add_sum  = {1'b0, add_op} + {1'b0, imm};
   assign pc_inc   = pc_q + ADDR_W'(1);
   assign jump_tgt = imm[ADDR_W-1:0];

   // NOTE: every register, IR included, is cleared by reset so an abandoned
   // instruction leaves no trace; nothing here is a RAM that would forbid a reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_FETCH;
         pc_q     <= '0;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         out_q    <= '0;
         strobe_q <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment; the blocking
         // assignments in the always_comb below are intentional and combinational.
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         carry_q  <= carry_d;
         out_q    <= out_d;
         strobe_q <= strobe_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      a_d        = a_q;
      b_d        = b_q;
      carry_d    = carry_q;
      out_d      = out_q;
      strobe_d   = 1'b0;
      halted_d   = halted_q;
      jump_taken = 1'b0;

      unique case (state_q)
         S_FETCH: begin
            if (fetch.fetch_valid) begin
               ir_d    = fetch.fetch_data;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_FETCH;
            pc_d    = pc_inc;
            carry_d = 1'b0;
            case (opcode)
               OP_ADD_A:  {carry_d, a_d} = add_sum;
               OP_MOV_AB: a_d = b_q;
               OP_IN_A:   a_d = sync_in;
               OP_MOV_AI: a_d = imm;
               OP_MOV_BA: b_d = a_q;
               OP_ADD_B:  {carry_d, b_d} = add_sum;
               OP_IN_B:   b_d = sync_in;
               OP_MOV_BI: b_d = imm;
               OP_OUT_B: begin
                  out_d    = b_q;
                  strobe_d = 1'b1;
               end
               OP_OUT_I: begin
                  out_d    = imm;
                  strobe_d = 1'b1;
               end
               OP_JMP:    jump_taken = 1'b1;
               // JNC looks at the carry left by the previous instruction.
               OP_JNC:    jump_taken = !carry_q;
               default:   ;
            endcase
            if (jump_taken) begin
               pc_d = jump_tgt;
               if (jump_tgt == pc_q) halted_d = 1'b1;
            end
         end
         default: state_d = S_FETCH;
      endcase
   end

   assign fetch.fetch_req  = reset & (state_q == S_FETCH);
   assign fetch.fetch_addr = pc_q;
   assign out_port         = out_q;
   assign out_strobe       = strobe_q;
   assign carry            = carry_q;
   assign halted           = halted_q;

endmodule

// File: tb/tb_tw_core.sv
// Bench for tw_core: an instruction-level ISA model runs alongside the DUT, with
// directed programs for carry/JNC, OUT strobes, wait states, halt, input sync and pc wrap,
// followed by random programs with random wait states and random mid-instruction resets.
module tb_tw_core;
   localparam int DATA_W      = 8;
   localparam int ADDR_W      = 4;
   localparam int SYNC_STAGES = 2;
   localparam int DMOD        = 1 << DATA_W;
   localparam int AMOD        = 1 << ADDR_W;

   typedef logic [DATA_W+3:0] instr_t;

   logic              clock   = 1'b0;
   logic              reset   = 1'b1;
   logic [DATA_W-1:0] in_port = '0;
   logic [DATA_W-1:0] out_port;
   logic              out_strobe;
   logic              carry;
   logic              halted;

   instr_t rom [AMOD];
   instr_t junk = '0;

   tw_core_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   // Garbage on the data bus whenever it is not marked valid.
   assign bus.fetch_data = bus.fetch_valid ? rom[bus.fetch_addr] : junk;

   tw_core #(
      .DATA_W      (DATA_W),
      .ADDR_W      (ADDR_W),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .fetch      (bus),
      .in_port    (in_port),
      .out_port   (out_port),
      .out_strobe (out_strobe),
      .carry      (carry),
      .halted     (halted)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   // Architectural model state.
   int m_a, m_b, m_c, m_pc, m_out, m_strobe, m_halt;

   // in_port value seen at each rising edge since reset; the core sees it SYNC_STAGES edges late.
   int hist[$];
   bit in_freeze = 1'b0;

   always @(posedge clock) begin
      if (!reset) begin
         hist.delete();
         for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(0);
      end else begin
         hist.push_back(int'(in_port));
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic instr_t ins(input int op, input int imm);
      instr_t r;
      r[DATA_W+3:DATA_W] = op[3:0];
      r[DATA_W-1:0]      = imm[DATA_W-1:0];
      return r;
   endfunction

   task automatic next_cycle();
      @(negedge clock);
      junk = instr_t'($urandom);
      if (!in_freeze) in_port = DATA_W'($urandom);
   endtask

   task automatic model_reset();
      m_a = 0; m_b = 0; m_c = 0; m_pc = 0; m_out = 0; m_strobe = 0; m_halt = 0;
   endtask

   // Called during the EXEC cycle, before the executing edge.
   task automatic model_exec();
      instr_t ir;
      int op, imm, nxt, c, tgt, sync_in;
      bit take;
      ir       = rom[m_pc];
      op       = int'(ir[DATA_W+3:DATA_W]);
      imm      = int'(ir[DATA_W-1:0]);
      nxt      = (m_pc + 1) % AMOD;
      tgt      = imm % AMOD;
      sync_in  = hist[hist.size() - SYNC_STAGES];
      c        = 0;
      take     = 1'b0;
      m_strobe = 0;
      case (op)
         0:  begin m_a = m_a + imm; c = m_a / DMOD; m_a = m_a % DMOD; end
         1:  m_a = m_b;
         2:  m_a = sync_in;
         3:  m_a = imm;
         4:  m_b = m_a;
         5:  begin m_b = m_b + imm; c = m_b / DMOD; m_b = m_b % DMOD; end
         6:  m_b = sync_in;
         7:  m_b = imm;
         9:  begin m_out = m_b; m_strobe = 1; end
         11: begin m_out = imm; m_strobe = 1; end
         14: take = 1'b1;
         15: take = (m_c == 0);
         default: ;
      endcase
      if (take) begin
         if (tgt == m_pc) m_halt = 1;
         nxt = tgt;
      end
      m_c  = c;
      m_pc = nxt;
   endtask

   // One instruction: entered and left just after a falling edge with the core in FETCH.
   task automatic step(input int waits);
      check("fetch_req", 32'(bus.fetch_req), 1);
      check("fetch_addr", 32'(bus.fetch_addr), m_pc);
      for (int w = 0; w < waits; w++) begin
         bus.fetch_valid = 1'b0;
         next_cycle();
         check("wait_req", 32'(bus.fetch_req), 1);
         check("wait_addr", 32'(bus.fetch_addr), m_pc);
         check("wait_carry", 32'(carry), m_c);
         check("wait_out", 32'(out_port), m_out);
         check("wait_strobe", 32'(out_strobe), 0);
      end
      bus.fetch_valid = 1'b1;
      next_cycle();
      check("exec_req", 32'(bus.fetch_req), 0);
      check("exec_strobe", 32'(out_strobe), 0);
      bus.fetch_valid = 1'($urandom);
      model_exec();
      next_cycle();
      check("out_port", 32'(out_port), m_out);
      check("out_strobe", 32'(out_strobe), m_strobe);
      check("carry", 32'(carry), m_c);
      check("halted", 32'(halted), m_halt);
   endtask

   // Reset from FETCH, or from EXEC after latching an instruction; ends in the first FETCH cycle.
   task automatic do_reset(input bit in_exec);
      if (in_exec) begin
         bus.fetch_valid = 1'b1;
         next_cycle();
      end
      #1 reset = 1'b0;
      #1;
      model_reset();
      check("rst_req", 32'(bus.fetch_req), 0);
      check("rst_out", 32'(out_port), 0);
      check("rst_strobe", 32'(out_strobe), 0);
      check("rst_carry", 32'(carry), 0);
      check("rst_halted", 32'(halted), 0);
      bus.fetch_valid = 1'b0;
      next_cycle();
      next_cycle();
      reset = 1'b1;
      #1;
      check("rel_req", 32'(bus.fetch_req), 1);
      check("rel_addr", 32'(bus.fetch_addr), 0);
   endtask

   initial begin
      bus.fetch_valid = 1'b0;
      model_reset();

      // Carry, JNC, OUT strobes, wait states at address 2, halt at 13.
      for (int i = 0; i < AMOD; i++) rom[i] = ins(8, 0);
      rom[0]  = ins(3, 'hFF);
      rom[1]  = ins(0, 1);
      rom[2]  = ins(15, 7);
      rom[3]  = ins(8, 0);
      rom[4]  = ins(15, 7);
      rom[5]  = ins(7, 'h11);
      rom[6]  = ins(7, 'h11);
      rom[7]  = ins(4, 0);
      rom[8]  = ins(9, 0);
      rom[9]  = ins(11, 9);
      rom[10] = ins(7, 9);
      rom[11] = ins(9, 0);
      rom[12] = ins(13, 0);
      rom[13] = ins(14, 13);
      do_reset(1'b0);
      step(0);
      step(0);
      check("add_carry", 32'(carry), 1);
      step(3);
      check("jnc_not_taken", 32'(bus.fetch_addr), 3);
      check("jnc_clears_c", 32'(carry), 0);
      step(0);
      step(0);
      check("jnc_taken", 32'(bus.fetch_addr), 7);
      step(0);
      step(1);
      check("out_b_zero", 32'(out_port), 0);
      step(0);
      check("out_imm", 32'(out_port), 9);
      check("out_imm_strobe", 32'(out_strobe), 1);
      step(0);
      check("strobe_1cyc", 32'(out_strobe), 0);
      step(2);
      check("out_b_same", 32'(out_port), 9);
      check("out_b_strobe", 32'(out_strobe), 1);
      step(0);
      step(0);
      check("halt_set", 32'(halted), 1);
      check("halt_addr", 32'(bus.fetch_addr), 13);
      repeat (3) step($urandom_range(0, 2));
      check("halt_sticky", 32'(halted), 1);
      check("halt_loop", 32'(bus.fetch_addr), 13);
      bus.fetch_valid = 1'b0;
      next_cycle();
      do_reset(1'b0);
      check("halt_cleared", 32'(halted), 0);

      // Input synchroniser, ADD B wrap, jump with ignored upper imm bits, pc wrap.
      for (int i = 0; i < AMOD; i++) rom[i] = ins(8, 0);
      rom[0] = ins(10, 0);
      rom[1] = ins(12, 0);
      rom[2] = ins(6, 0);
      rom[3] = ins(9, 0);
      rom[4] = ins(5, 'h5B);
      rom[5] = ins(9, 0);
      rom[6] = ins(14, 'h3C);
      in_freeze = 1'b1;
      in_port   = 8'hA5;
      do_reset(1'b1);
      step(0);
      step(0);
      step(0);
      step(0);
      check("in_b", 32'(out_port), 'hA5);
      step(0);
      check("add_b_carry", 32'(carry), 1);
      step(0);
      check("add_b_wrap", 32'(out_port), 0);
      step(0);
      check("jmp_hi_ignored", 32'(bus.fetch_addr), 'hC);
      repeat (4) step(0);
      check("pc_wrap", 32'(bus.fetch_addr), 0);
      in_freeze = 1'b0;

      // Random programs, wait states, input traffic and resets.
      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < AMOD; i++) rom[i] = ins($urandom_range(0, 15), $urandom);
         do_reset(1'($urandom));
         repeat (80) step(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
